// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types and constants.
// Holds the fetch FSM encoding and PC arithmetic constants.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    function automatic logic word_aligned(input logic [XLEN-1:0] a);
        return a[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC select: redirect target, sequential PC+4 or hold.
// Misaligned redirect targets are rejected here.
module pc_next_mux
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] target,
    input  logic            redirect,
    input  logic            advance,
    output logic [XLEN-1:0] pc_next,
    output logic            accept,
    output logic            misalign
);

    logic step;

    always_comb begin
        accept   = redirect & word_aligned(target);
        misalign = redirect & ~word_aligned(target);
        step     = advance & ~accept;
        pc_next  = pc;
        unique case (1'b1)
            accept:  pc_next = target;
            step:    pc_next = pc + PC_INC;
            default: pc_next = pc;
        endcase
    end

endmodule

// File: rtl/fetch_pc.sv
// Instruction fetch PC unit: request/ack memory port, redirects,
// stalls, and dropping of wrong-path responses.
module fetch_pc
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic            jump,
    input  logic [XLEN-1:0] target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc_out,
    output logic            flush,
    output logic            misalign_err
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic            accept;
    logic            misalign;
    logic            advance;
    logic            armed;

    assign advance = (state == FETCH) & imem_req & imem_ack;

    pc_next_mux u_mux (
        .pc       (pc),
        .target   (target),
        .redirect (branch_taken | jump),
        .advance  (advance),
        .pc_next  (pc_next),
        .accept   (accept),
        .misalign (misalign)
    );

    // armed delays the first request to the second edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            armed        <= 1'b0;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            instr_valid  <= 1'b0;
            instr        <= '0;
            pc_out       <= '0;
            flush        <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            pc           <= pc_next;
            armed        <= 1'b1;
            flush        <= accept;
            misalign_err <= misalign;
            instr_valid  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!accept && !stall && armed) begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (!imem_req) begin
                        if (accept || stall) begin
                            state <= IDLE;
                        end else begin
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                        end
                    end else if (imem_ack) begin
                        imem_req <= 1'b0;
                        if (accept) begin
                            state <= IDLE;
                        end else begin
                            instr_valid <= 1'b1;
                            instr       <= imem_rdata;
                            pc_out      <= pc;
                            state       <= stall ? IDLE : FETCH;
                        end
                    end else if (accept) begin
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc.sv
// Scoreboard bench for fetch_pc: directed phases push expected
// deliveries, a monitor pops and compares on instr_valid.
module tb_fetch_pc;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall, branch_taken, jump;
    logic [31:0] target;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        instr_valid, flush, misalign_err;
    logic [31:0] instr, pc_out;

    logic        stall2, imem_req2, imem_ack2;
    logic [31:0] imem_addr2, imem_rdata2;
    logic        instr_valid2, flush2, misalign_err2;
    logic [31:0] instr2, pc_out2;

    exp_t sb[$];
    exp_t sb2[$];

    int total = 0;
    int bad = 0;
    int ack_delay = 0;
    int req_count = 0;
    int flush_seen = 0;
    int mis_seen = 0;
    logic [31:0] last_req_addr = '0;

    always #5 clk = ~clk;

    fetch_pc dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .jump         (jump),
        .target       (target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .pc_out       (pc_out),
        .flush        (flush),
        .misalign_err (misalign_err)
    );

    fetch_pc #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall2),
        .branch_taken (1'b0),
        .jump         (1'b0),
        .target       (32'h0),
        .imem_req     (imem_req2),
        .imem_addr    (imem_addr2),
        .imem_ack     (imem_ack2),
        .imem_rdata   (imem_rdata2),
        .instr_valid  (instr_valid2),
        .instr        (instr2),
        .pc_out       (pc_out2),
        .flush        (flush2),
        .misalign_err (misalign_err2)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a);
        sb.push_back({a, a ^ KEY});
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_req(input int budget, input string name);
        int n = 0;
        while (n < budget) begin
            @(negedge clk);
            #1;
            n++;
            if (imem_req) break;
        end
        chk(name, {31'd0, imem_req}, 32'd1);
    endtask

    // Memory model: ack ack_delay cycles after a request is seen
    initial begin
        int  cnt = 0;
        logic acked = 1'b0;
        logic req_prev = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (imem_req && !req_prev) begin
                req_count++;
                last_req_addr = imem_addr;
                cnt = 0;
            end
            if (imem_req && !acked) begin
                if (cnt >= ack_delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = imem_addr ^ KEY;
                    acked      = 1'b1;
                end else begin
                    cnt++;
                end
            end
            if (!imem_req) acked = 1'b0;
            req_prev = imem_req;
        end
    end

    initial begin
        imem_ack2   = 1'b0;
        imem_rdata2 = '0;
        forever begin
            @(negedge clk);
            imem_ack2   = imem_req2 && !imem_ack2;
            imem_rdata2 = imem_addr2 ^ KEY;
        end
    end

    // Monitor for the main instance
    initial begin
        logic        req_q = 1'b0;
        logic        ack_q = 1'b0;
        logic [31:0] addr_q = '0;
        exp_t        e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n) begin
                if (instr_valid) begin
                    chk("latency_ack", {31'd0, imem_ack}, 32'd1);
                    if (sb.size() == 0) begin
                        chk("extra_valid_pc", pc_out, 32'hDEAD_DEAD);
                    end else begin
                        e = sb.pop_front();
                        chk("pc_out", pc_out, e.pc);
                        chk("instr", instr, e.ins);
                    end
                end
                if (flush) flush_seen++;
                if (misalign_err) mis_seen++;
                if (imem_req && req_q && !ack_q)
                    chk("addr_hold", imem_addr, addr_q);
            end
            req_q  = imem_req;
            ack_q  = imem_ack;
            addr_q = imem_addr;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && instr_valid2 && sb2.size() != 0) begin
                e = sb2.pop_front();
                chk("wrap_pc_out", pc_out2, e.pc);
                chk("wrap_instr", instr2, e.ins);
            end
        end
    end

    initial begin
        int n;
        int edges;
        stall        = 1'b0;
        stall2       = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        target       = '0;
        sb2.push_back({32'hFFFF_FFFC, 32'hFFFF_FFFC ^ KEY});
        sb2.push_back({32'h0000_0000, KEY});

        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_mis", {31'd0, misalign_err}, 32'd0);
        chk("rst_addr2", imem_addr2, 32'hFFFF_FFFC);

        // sequential fetch from reset
        for (int i = 0; i < 4; i++) push(32'(i * 4));
        rst_n = 1'b1;
        drain(60, "seq_drain");
        stall = 1'b1;

        // branch while a request waits for its ack
        repeat (3) @(negedge clk);
        #1;
        ack_delay = 3;
        stall = 1'b0;
        wait_req(20, "br_req");
        branch_taken = 1'b1;
        target = 32'h0000_0100;
        @(negedge clk);
        #1;
        branch_taken = 1'b0;
        target = '0;
        push(32'h0000_0100);
        drain(60, "br_drain");
        stall = 1'b1;
        chk("br_addr", last_req_addr, 32'h0000_0100);
        chk("br_flush", 32'(flush_seen), 32'd1);

        // misaligned jump is rejected
        repeat (3) @(negedge clk);
        #1;
        ack_delay = 0;
        push(32'h0000_0104);
        push(32'h0000_0108);
        stall = 1'b0;
        jump = 1'b1;
        target = 32'h0000_0202;
        @(negedge clk);
        #1;
        jump = 1'b0;
        target = '0;
        drain(60, "mis_drain");
        stall = 1'b1;
        chk("mis_cnt", 32'(mis_seen), 32'd1);
        chk("mis_noflush", 32'(flush_seen), 32'd1);

        // stall rises with a request outstanding
        repeat (3) @(negedge clk);
        #1;
        ack_delay = 3;
        push(32'h0000_010C);
        stall = 1'b0;
        wait_req(20, "st_req");
        stall = 1'b1;
        n = req_count;
        drain(60, "st_drain");
        repeat (6) @(negedge clk);
        #1;
        chk("st_noreq", 32'(req_count), 32'(n));
        chk("st_req_low", {31'd0, imem_req}, 32'd0);
        push(32'h0000_0110);
        stall = 1'b0;
        drain(60, "st_resume");
        stall = 1'b1;

        // reset while a request is outstanding
        repeat (3) @(negedge clk);
        #1;
        stall = 1'b0;
        wait_req(20, "rr_req");
        rst_n = 1'b0;
        #1;
        chk("rr_req_low", {31'd0, imem_req}, 32'd0);
        chk("rr_addr", imem_addr, 32'h0);
        chk("rr_valid", {31'd0, instr_valid}, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        ack_delay = 0;
        push(32'h0000_0000);
        rst_n = 1'b1;
        edges = 0;
        while (edges < 10) begin
            @(posedge clk);
            edges++;
            #1;
            if (imem_req) break;
        end
        chk("rr_edges", {31'd0, (edges >= 2) && imem_req}, 32'd1);
        drain(60, "rr_drain");
        stall = 1'b1;
        chk("rr_first_addr", last_req_addr, 32'h0);
        chk("wrap_done", 32'(sb2.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
